// File: rtl/wave_bank_arb.sv
// Wavetable RAM arbiter: NUM_BANKS independent DEPTH x DATA_W banks shared by
// NUM_VOICES oscillator readers through a round-robin, fixed-latency-2 read
// pipeline. One broadcast-capable write port loads the tables.

// One wave bank: single write port, registered read port.
// A read and a write to the same address on the same edge returns the old word.
module wave_bank_arb_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write and registered read share one block so a same-address read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// Per-voice output slice: holds the last sample delivered to this voice.
module wave_bank_arb_lane #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  // Capture the muxed bank word only when this voice's read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end
endmodule

module wave_bank_arb #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int NUM_BANKS  = 4,
  parameter int NUM_VOICES = 3,
  parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         wr_valid,
  input  logic [NUM_BANKS-1:0]         wr_mask,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [NUM_VOICES-1:0]        rd_req,
  input  logic [NUM_VOICES*BANK_W-1:0] rd_bank,
  input  logic [NUM_VOICES*ADDR_W-1:0] rd_addr,
  output logic [NUM_VOICES-1:0]        rd_ack,
  output logic [NUM_VOICES-1:0]        rd_valid,
  output logic [NUM_VOICES*DATA_W-1:0] rd_data
);
  localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int STAGES  = 2;

  typedef struct packed {
    logic [VOICE_W-1:0] voice;
    logic [BANK_W-1:0]  bank;
  } tag_t;

  logic [VOICE_W-1:0]                   last_grant;
  logic                                 gnt_any;
  logic [VOICE_W-1:0]                   gnt_idx;
  logic [BANK_W-1:0]                    gnt_bank;
  logic [ADDR_W-1:0]                    gnt_addr;
  logic [STAGES:1]                      vld_pipe;
  tag_t                                 s1;
  logic [VOICE_W-1:0]                   s2_voice;
  logic [NUM_BANKS-1:0][DATA_W-1:0]     ram_q;
  logic [DATA_W-1:0]                    bank_sel;
  logic [NUM_VOICES-1:0][DATA_W-1:0]    voice_q;
  logic                                 wr_fire;

  assign wr_fire = wr_valid & wr_en;
  assign rd_data = voice_q;

  // Round robin: first requester above the last grant, otherwise wrap to the lowest requester.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_bank = '0;
    gnt_addr = '0;
    for (int u = 0; u < NUM_VOICES; u++) begin
      if (!gnt_any && rd_req[u] && (VOICE_W'(u) > last_grant)) begin
        gnt_any  = 1'b1;
        gnt_idx  = VOICE_W'(u);
        gnt_bank = rd_bank[u*BANK_W +: BANK_W];
        gnt_addr = rd_addr[u*ADDR_W +: ADDR_W];
      end
    end
    for (int u = 0; u < NUM_VOICES; u++) begin
      if (!gnt_any && rd_req[u] && (VOICE_W'(u) <= last_grant)) begin
        gnt_any  = 1'b1;
        gnt_idx  = VOICE_W'(u);
        gnt_bank = rd_bank[u*BANK_W +: BANK_W];
        gnt_addr = rd_addr[u*ADDR_W +: ADDR_W];
      end
    end
  end

  // One-hot grant straight from the arbiter.
  always_comb begin
    rd_ack = '0;
    for (int u = 0; u < NUM_VOICES; u++)
      rd_ack[u] = gnt_any && (gnt_idx == VOICE_W'(u));
  end

  // Every bank sees the granted address; only the stage-1 bank is used downstream.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    wave_bank_arb_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (wr_fire & wr_mask[b]),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (gnt_any),
      .raddr (gnt_addr),
      .rdata (ram_q[b])
    );
  end

  // Valid shift register plus the tags that follow each read down the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe   <= '0;
      last_grant <= VOICE_W'(NUM_VOICES-1);
      s1         <= '0;
      s2_voice   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], gnt_any};
      if (gnt_any) last_grant <= gnt_idx;
      s1       <= '{voice: gnt_idx, bank: gnt_bank};
      s2_voice <= s1.voice;
    end
  end

  // Bank select; codes with no bank behind them read as zero.
  always_comb begin
    bank_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (s1.bank == BANK_W'(b)) bank_sel = ram_q[b];
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_lane
    wave_bank_arb_lane #(.DATA_W(DATA_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (vld_pipe[1] && (s1.voice == VOICE_W'(v))),
      .d    (bank_sel),
      .q    (voice_q[v])
    );
  end

  // Completion pulse for the voice whose slice was just loaded.
  always_comb begin
    rd_valid = '0;
    for (int u = 0; u < NUM_VOICES; u++)
      rd_valid[u] = vld_pipe[STAGES] && (s2_voice == VOICE_W'(u));
  end
endmodule

// File: tb/tb_wave_bank_arb.sv
// Randomized + directed bench for wave_bank_arb. Two instances: the default
// 4-bank / 3-voice build and a 3-bank / 1-voice / 9-bit-address build.
module tb_wave_bank_arb;
  localparam int NV = 3, NB = 4, AW = 8, DW = 16, BW = 2;
  localparam int NB2 = 3, AW2 = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 wr_en, wr_valid;
  logic [NB-1:0]        wr_mask;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic [NV-1:0]        rd_req;
  logic [NV-1:0][BW-1:0] bank_p;
  logic [NV-1:0][AW-1:0] addr_p;
  logic [NV-1:0]        rd_ack, rd_valid;
  logic [NV*DW-1:0]     rd_data;

  logic                 w2_en, w2_valid;
  logic [NB2-1:0]       w2_mask;
  logic [AW2-1:0]       w2_addr;
  logic [DW-1:0]        w2_data;
  logic [0:0]           r2_req, r2_ack, r2_valid;
  logic [1:0]           r2_bank;
  logic [AW2-1:0]       r2_addr;
  logic [DW-1:0]        r2_data;

  wave_bank_arb #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB), .NUM_VOICES(NV)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_valid(wr_valid), .wr_mask(wr_mask),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_req(rd_req), .rd_bank(bank_p),
    .rd_addr(addr_p), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data));

  wave_bank_arb #(.DATA_W(DW), .ADDR_W(AW2), .NUM_BANKS(NB2), .NUM_VOICES(1)) dut2 (
    .clk(clk), .rst(rst), .wr_en(w2_en), .wr_valid(w2_valid), .wr_mask(w2_mask),
    .wr_addr(w2_addr), .wr_data(w2_data), .rd_req(r2_req), .rd_bank(r2_bank),
    .rd_addr(r2_addr), .rd_ack(r2_ack), .rd_valid(r2_valid), .rd_data(r2_data));

  typedef struct { int due; int voice; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];
  exp_t sb2[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  logic done = 1'b0;

  // Reference state: plain memory arrays and a "who was served last" index.
  logic [DW-1:0]        mem_m  [NB][256];
  logic [DW-1:0]        mem2_m [NB2][512];
  logic [NV-1:0][DW-1:0] exp_data;
  logic [DW-1:0]        exp2;
  int                   ptr;
  logic [NV-1:0]        last_ack;
  logic [0:0]           last_ack2;

  // Model: predict the grant, queue the expected sample, then apply the write.
  always @(negedge clk) begin
    int g;
    logic [NV-1:0] want;
    if (rst) begin
      sb.delete();
      ptr = NV - 1;
      last_ack = '0;
    end else begin
      g = -1;
      for (int k = 1; k <= NV; k++)
        if (g < 0 && rd_req[(ptr + k) % NV]) g = (ptr + k) % NV;
      want = (g < 0) ? '0 : (NV'(1) << g);
      n_cmp++;
      if (rd_ack !== want) begin
        n_err++;
        $display("FAIL rd_ack cyc=%0d got=%b want=%b", cyc, rd_ack, want);
      end
      last_ack = want;
      if (g >= 0) begin
        sb.push_back('{cyc + 2, g, mem_m[int'(bank_p[g])][int'(addr_p[g])]});
        ptr = g;
      end
      if (wr_valid && wr_en)
        for (int b = 0; b < NB; b++)
          if (wr_mask[b]) mem_m[b][int'(wr_addr)] = wr_data;
    end
  end

  // Monitor: pop on the cycle a sample is due and check every slice.
  always @(negedge clk) begin
    exp_t e;
    logic fin;
    if (rst) begin
      exp_data = '0;
      n_cmp++;
      if (rd_valid !== '0 || rd_data !== '0) begin
        n_err++;
        $display("FAIL reset_out cyc=%0d got valid=%b data=%h want 0", cyc, rd_valid, rd_data);
      end
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_data[e.voice] = e.data;
      n_cmp++;
      if (rd_valid !== (NV'(1) << e.voice) || rd_data !== exp_data) begin
        n_err++;
        $display("FAIL read cyc=%0d voice=%0d got valid=%b data=%h want valid=%b data=%h",
                 cyc, e.voice, rd_valid, rd_data, NV'(1) << e.voice, exp_data);
      end
    end else begin
      n_cmp++;
      if (rd_valid !== '0 || rd_data !== exp_data) begin
        n_err++;
        $display("FAIL idle cyc=%0d got valid=%b data=%h want valid=0 data=%h",
                 cyc, rd_valid, rd_data, exp_data);
      end
    end
    if (done && fin !== 1'b1) begin
      fin = 1'b1;
      n_cmp++;
      if (sb.size() != 0 || sb2.size() != 0) begin
        n_err++;
        $display("FAIL drain got pending=%0d/%0d want 0/0", sb.size(), sb2.size());
      end
    end
  end

  // Model for the single-voice build: always granted, out-of-range bank reads zero.
  always @(negedge clk) begin
    int bk;
    if (rst) begin
      sb2.delete();
      last_ack2 = '0;
    end else begin
      n_cmp++;
      if (r2_ack !== r2_req) begin
        n_err++;
        $display("FAIL rd_ack2 cyc=%0d got=%b want=%b", cyc, r2_ack, r2_req);
      end
      last_ack2 = r2_req;
      bk = int'(r2_bank);
      if (r2_req[0])
        sb2.push_back('{cyc + 2, 0, (bk < NB2) ? mem2_m[bk][int'(r2_addr)] : '0});
      if (w2_valid && w2_en)
        for (int b = 0; b < NB2; b++)
          if (w2_mask[b]) mem2_m[b][int'(w2_addr)] = w2_data;
    end
  end

  // Monitor for the single-voice build.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp2 = '0;
    end else if (sb2.size() > 0 && sb2[0].due == cyc) begin
      e = sb2.pop_front();
      exp2 = e.data;
      n_cmp++;
      if (r2_valid !== 1'b1 || r2_data !== exp2) begin
        n_err++;
        $display("FAIL read2 cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                 cyc, r2_valid, r2_data, exp2);
      end
    end else if (r2_valid !== 1'b0 || r2_data !== exp2) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle2 cyc=%0d got valid=%b data=%h want valid=0 data=%h",
               cyc, r2_valid, r2_data, exp2);
    end
  end

  // Advance one cycle, then drop acked requests and single-cycle write strobes.
  task automatic step();
    @(posedge clk);
    #1;
    rd_req   = rd_req & ~last_ack;
    r2_req   = r2_req & ~last_ack2;
    wr_valid = 1'b0;
    w2_valid = 1'b0;
  endtask

  task automatic rq(input int v, input int b, input int a);
    rd_req[v] = 1'b1;
    bank_p[v] = BW'(b);
    addr_p[v] = AW'(a);
  endtask

  task automatic rq_when_free(input int v, input int b, input int a);
    for (int t = 0; t < 8 && rd_req[v]; t++) step();
    rq(v, b, a);
  endtask

  task automatic wr(input logic [NB-1:0] m, input int a, input logic [DW-1:0] d, input logic en);
    wr_valid = 1'b1;
    wr_en    = en;
    wr_mask  = m;
    wr_addr  = AW'(a);
    wr_data  = d;
  endtask

  initial begin
    wr_en = 0; wr_valid = 0; wr_mask = '0; wr_addr = '0; wr_data = '0;
    rd_req = '0; bank_p = '0; addr_p = '0;
    w2_en = 0; w2_valid = 0; w2_mask = '0; w2_addr = '0; w2_data = '0;
    r2_req = '0; r2_bank = '0; r2_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Preload the small address window used by random reads.
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 4; a++) begin
        wr(NB'(1 << b), a, 16'($urandom), 1'b1);
        step();
      end

    // All voices requesting continuously: 0,1,2,0,1,2,...
    for (int i = 0; i < 9; i++) begin
      for (int v = 0; v < NV; v++)
        if (!rd_req[v]) rq(v, $urandom % 4, $urandom % 4);
      step();
    end
    repeat (6) step();

    // Single voice latency check.
    wr(4'b0100, 'h10, 16'hBEEF, 1'b1);
    step();
    rq(1, 2, 'h10);
    step();
    repeat (4) step();

    // Broadcast write, then a disabled write that must not land.
    wr(4'b1111, 'hFF, 16'h1234, 1'b1);
    step();
    wr(4'b1111, 'hFF, 16'h5555, 1'b0);
    step();
    rq(0, 0, 'hFF); rq(1, 1, 'hFF); rq(2, 2, 'hFF);
    step();
    rq_when_free(0, 3, 'hFF);
    step();
    repeat (6) step();

    // Read/write collision on bank0/0x00.
    wr(4'b0001, 0, 16'hAAAA, 1'b1);
    step();
    wr(4'b0001, 0, 16'h5555, 1'b1);
    rq(0, 0, 0);
    step();
    rq_when_free(0, 0, 0);
    step();
    repeat (4) step();

    // Single-voice build: top address and an unpopulated bank code.
    w2_valid = 1'b1; w2_en = 1'b1; w2_mask = 3'b111; w2_addr = 9'h1FF; w2_data = 16'hC0DE;
    step();
    r2_req = 1'b1; r2_bank = 2'd0; r2_addr = 9'h1FF;
    step();
    r2_req = 1'b1; r2_bank = 2'd2; r2_addr = 9'h1FF;
    step();
    r2_req = 1'b1; r2_bank = 2'd3; r2_addr = 9'h1FF;
    step();
    repeat (4) step();

    // Random traffic with a reset dropped into the middle of streaming reads.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b1;
        rd_req = '0;
        step();
        step();
        rst = 1'b0;
        for (int v = 0; v < NV; v++) rq(v, $urandom % 4, $urandom % 4);
        step();
      end else begin
        for (int v = 0; v < NV; v++)
          if (!rd_req[v] && ($urandom % 3) != 0) rq(v, $urandom % 4, $urandom % 4);
        if ($urandom % 2) wr(NB'($urandom), $urandom % 4, 16'($urandom), ($urandom % 4) != 0);
        step();
      end
    end

    repeat (8) step();
    done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
